// File: rtl/rv_mul_seq_if.sv
// ---------------------------------------------------------------------------
// rv_mul_seq_if
//
// Purpose: groups the request/response signals of the sequential RV32M
// multiplier so the EX stage and the multiplier can be connected with a
// single port.
//
// Signals:
//   start_i  - request a new operation (accepted only in IDLE or DONE)
//   op_i     - funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src1     - multiplicand (rs1), sampled with start_i
//   src2     - multiplier (rs2), sampled with start_i
//   kill_i   - flush, abandons any operation in progress
//   busy_o   - high while the multiplier is iterating
//   valid_o  - one-cycle pulse, result_o is valid
//   result_o - selected 32-bit half of the product
//
// Modports:
//   master - the requester (pipeline / testbench) driving the operands
//   slave  - the multiplier itself
// ---------------------------------------------------------------------------
interface rv_mul_seq_if;

    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        kill_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    // The requester drives the operation and watches the handshake.
    modport master (
        output start_i,
        output op_i,
        output src1,
        output src2,
        output kill_i,
        input  busy_o,
        input  valid_o,
        input  result_o
    );

    // The multiplier consumes the operation and produces the result.
    modport slave (
        input  start_i,
        input  op_i,
        input  src1,
        input  src2,
        input  kill_i,
        output busy_o,
        output valid_o,
        output result_o
    );

endinterface

// File: rtl/rv_mul_seq.sv
// ---------------------------------------------------------------------------
// rv_mul_seq
//
// Purpose: multi-cycle RV32M multiplier (MUL, MULH, MULHSU, MULHU). Operands
// are converted to magnitudes at start, multiplied by radix-2 shift-add over
// 32 iterations, and the 64-bit product is negated at the end when the
// operand signs differ. The selected 32-bit half is registered on the edge
// that completes the last iteration and announced with a one-cycle valid.
//
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - rv_mul_seq_if.slave: start_i, op_i, src1, src2, kill_i in;
//            busy_o, valid_o, result_o out
//
// Latency: a start accepted on the edge ending cycle N gives busy_o in
// cycles N+1..N+32 and valid_o in cycle N+33, independent of operand values.
// ---------------------------------------------------------------------------
module rv_mul_seq (
    input  logic          clk_i,
    input  logic          rst_ni,
    rv_mul_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state;
    state_t      state_next;

    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [1:0]  op_q;
    logic        neg_q;
    logic [31:0] result_q;

    logic        src1_signed;
    logic        src2_signed;
    logic        src1_neg;
    logic        src2_neg;
    logic [31:0] src1_mag;
    logic [31:0] src2_mag;
    logic        neg_in;

    logic        accept;
    logic        calc_step;
    logic        last_step;

    logic [32:0] addend;
    logic [32:0] sum;
    logic [63:0] prod_step;
    logic [63:0] final_prod;
    logic [31:0] result_sel;

    // Decode which operands are treated as signed for the requested op and
    // turn them into unsigned magnitudes. The two's-complement negation of
    // 0x80000000 is 0x80000000 again, which is exactly the magnitude 2^31
    // read as unsigned, so no special case is needed.
    always_comb begin
        src1_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU);
        src2_signed = (bus.op_i == OP_MULH);
        src1_neg    = src1_signed && bus.src1[31];
        src2_neg    = src2_signed && bus.src2[31];
        src1_mag    = src1_neg ? (~bus.src1 + 32'd1) : bus.src1;
        src2_mag    = src2_neg ? (~bus.src2 + 32'd1) : bus.src2;
        neg_in      = src1_neg ^ src2_neg;
    end

    // Handshake qualifiers. A kill always wins over a start, and a start seen
    // while iterating is simply not accepted.
    always_comb begin
        accept    = ((state == IDLE) || (state == DONE)) && bus.start_i && !bus.kill_i;
        calc_step = (state == CALC) && !bus.kill_i;
        last_step = calc_step && (cnt == 5'd31);
    end

    // One shift-add iteration. The multiplicand is added into the upper half
    // with a 33-bit sum so the carry is kept, then the whole {carry, P} is
    // shifted right by one. The low half of P collects finished product bits
    // as they fall out of the upper half.
    always_comb begin
        addend    = mplier[0] ? {1'b0, mcand} : 33'd0;
        sum       = {1'b0, prod[63:32]} + addend;
        prod_step = {sum, prod[31:1]};
    end

    // Sign fix-up and half selection, evaluated on the product that the last
    // iteration is about to produce so the result can be registered on the
    // same edge that leaves CALC.
    always_comb begin
        final_prod = neg_q ? (~prod_step + 64'd1) : prod_step;
        result_sel = (op_q == OP_MUL) ? final_prod[31:0] : final_prod[63:32];
    end

    // State register. Reset drops straight to IDLE from anywhere, including
    // the middle of an iteration, so no valid pulse can follow a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE only lasts one cycle unless a new start is
    // accepted in it, which makes back-to-back operations run every 33 cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.kill_i) begin
                    state_next = IDLE;
                end else if (bus.start_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    state_next = IDLE;
                end else if (cnt == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.kill_i) begin
                    state_next = IDLE;
                end else if (bus.start_i) begin
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands, op and the sign flag are captured on an
    // accepted start; each CALC cycle advances the product and multiplier by
    // one bit. The result register is only written on the final iteration so
    // it holds its value across kills and idle periods.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= 5'd0;
            mcand    <= 32'd0;
            mplier   <= 32'd0;
            prod     <= 64'd0;
            op_q     <= 2'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else if (accept) begin
            cnt    <= 5'd0;
            mcand  <= src1_mag;
            mplier <= src2_mag;
            prod   <= 64'd0;
            op_q   <= bus.op_i;
            neg_q  <= neg_in;
        end else if (calc_step) begin
            cnt    <= cnt + 5'd1;
            prod   <= prod_step;
            mplier <= {1'b0, mplier[31:1]};
            if (last_step) begin
                result_q <= result_sel;
            end
        end
    end

    // Status outputs come straight from the state register.
    assign bus.busy_o   = (state == CALC);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_rv_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_rv_mul_seq
//
// Purpose: self-checking bench for rv_mul_seq. Directed cases cover latency,
// signed corner values, ignored starts, back-to-back starts, kill and
// asynchronous reset; a randomized sweep compares every result with a
// 64-bit arithmetic reference model.
//
// Ports: none (top-level bench). Drives the DUT through rv_mul_seq_if.
// ---------------------------------------------------------------------------
module tb_rv_mul_seq;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;
    int cyc;

    rv_mul_seq_if bus ();

    rv_mul_seq dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #1_200_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: extend each operand to 64 bits according to its signedness
    // and multiply modulo 2^64, which yields the exact low 64 bits of the
    // mathematical product.
    function automatic logic [31:0] refMul(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait for valid_o until the cycle counter reaches limit; at = -1 if none.
    task automatic waitValid(input int limit, output int at);
        at = -1;
        forever begin
            if (bus.valid_o) begin
                at = cyc;
                return;
            end
            if (cyc >= limit) return;
            tick();
        end
    endtask

    // One complete operation started in cycle 0, with latency, busy window,
    // result and the end of the valid pulse all checked.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp);
        int busy_cnt;
        int at;
        cyc         = 0;
        bus.op_i    = op;
        bus.src1    = a;
        bus.src2    = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.op_i    = 2'($urandom);
        bus.src1    = $urandom;
        bus.src2    = $urandom;
        busy_cnt    = 0;
        at          = -1;
        while (cyc < 40) begin
            if (bus.valid_o) begin
                at = cyc;
                break;
            end
            if (bus.busy_o) busy_cnt++;
            tick();
        end
        checkOutput({tag, "_latency"}, at, 33);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, 32);
        checkOutput({tag, "_result"}, bus.result_o, exp);
        tick();
        checkOutput({tag, "_valid_end"}, {31'd0, bus.valid_o}, 32'd0);
    endtask

    initial begin
        int at;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst_n        = 1'b1;
        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.op_i     = 2'b00;
        bus.src1     = 32'd0;
        bus.src2     = 32'd0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("reset_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed values
        applyStimulus("mul_7x6",        2'b00, 32'd7,        32'd6,        32'h0000_002A);
        applyStimulus("mulh_min_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        applyStimulus("mulh_m1_1",      2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
        applyStimulus("mulh_min_max",   2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000);
        applyStimulus("mulhsu_ff_ff",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mulhu_ff_ff",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        applyStimulus("mul_ff_ff",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // Start during CALC is ignored; start in DONE chains the next op
        cyc = 0;
        bus.op_i = 2'b00; bus.src1 = 32'd3; bus.src2 = 32'd5; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        while (cyc < 10) tick();
        bus.op_i = 2'b11; bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h1234_5678; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        waitValid(40, at);
        checkOutput("ignored_start_latency", at, 33);
        checkOutput("ignored_start_result", bus.result_o, 32'd15);
        bus.op_i = 2'b00; bus.src1 = 32'd100; bus.src2 = 32'd200; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checkOutput("b2b_busy_after_done", {31'd0, bus.busy_o}, 32'd1);
        waitValid(80, at);
        checkOutput("b2b_latency", at, 66);
        checkOutput("b2b_result", bus.result_o, 32'h0000_4E20);
        tick();

        // Kill and start together: kill wins, then a fresh start at 16
        cyc = 0;
        bus.op_i = 2'b00; bus.src1 = 32'd11; bus.src2 = 32'd13; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        while (cyc < 15) tick();
        bus.kill_i = 1'b1; bus.start_i = 1'b1; bus.op_i = 2'b01;
        tick();
        bus.kill_i = 1'b0; bus.start_i = 1'b0;
        checkOutput("kill_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("kill_idle_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("kill_result_held", bus.result_o, 32'h0000_4E20);
        bus.op_i = 2'b11; bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'd2; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        waitValid(60, at);
        checkOutput("after_kill_latency", at, 49);
        checkOutput("after_kill_result", bus.result_o, 32'h0000_0001);
        tick();

        // Lone kill in the last CALC cycle suppresses valid
        cyc = 0;
        bus.op_i = 2'b00; bus.src1 = 32'd9; bus.src2 = 32'd9; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        while (cyc < 32) tick();
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        checkOutput("late_kill_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("late_kill_busy", {31'd0, bus.busy_o}, 32'd0);
        waitValid(45, at);
        checkOutput("late_kill_no_valid", at, -1);
        checkOutput("late_kill_result_held", bus.result_o, 32'h0000_0001);

        // Asynchronous reset in the middle of CALC
        cyc = 0;
        bus.op_i = 2'b01; bus.src1 = 32'h1234_5678; bus.src2 = 32'h8765_4321; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        while (cyc < 10) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("async_reset_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("async_reset_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cyc = 0;
        waitValid(40, at);
        checkOutput("async_reset_no_stale_valid", at, -1);
        applyStimulus("post_reset_op", 2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        // Randomized sweep against the reference model
        for (int i = 0; i < 700; i++) begin
            r_op = 2'($urandom);
            r_a  = pickOperand();
            r_b  = pickOperand();
            applyStimulus($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, refMul(r_op, r_a, r_b));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
